// File: rtl/div_ctrl.sv
// Sequencer around an iterative unsigned divider core for DIV/DIVU/REM/REMU.
// Optional result cache: define DIV_RESULT_CACHE_EN.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_ready,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  input  logic            i_ready,
  output logic            o_busy,
  output logic            o_div_start,
  output logic [XLEN-1:0] o_div_rs1,
  output logic [XLEN-1:0] o_div_rs2,
  input  logic [XLEN-1:0] i_div_res,
  input  logic [XLEN-1:0] i_div_rem,
  input  logic            i_div_ok
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_BUSY, S_DONE, S_DRAIN
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_next;

  logic [XLEN-1:0] r_a, r_b, r_result;
  logic            r_neg_q, r_neg_r, r_rem;

  logic            w_acc, w_sgn, w_rem;
  logic            w_neg_a, w_neg_b;
  logic            w_zero, w_ovf, w_spec;
  logic            w_hit, w_cap;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic [XLEN-1:0] w_spec_val, w_hit_val;

  function automatic logic [XLEN-1:0] fix(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic            nq,
    input logic            nr,
    input logic            sel_rem
  );
    logic [XLEN-1:0] v;
    v = sel_rem ? r : q;
    if (sel_rem ? nr : nq) v = -v;
    return v;
  endfunction

  assign w_acc   = i_valid & (r_state == S_IDLE) & ~i_flush;
  assign w_sgn   = ~i_op[0];
  assign w_rem   = i_op[1];
  assign w_neg_a = w_sgn & i_rs1[XLEN-1];
  assign w_neg_b = w_sgn & i_rs2[XLEN-1];
  assign w_abs_a = w_neg_a ? -i_rs1 : i_rs1;
  assign w_abs_b = w_neg_b ? -i_rs2 : i_rs2;

  assign w_zero = (i_rs2 == '0);
  assign w_ovf  = w_sgn & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
  assign w_spec = w_zero | w_ovf;

  assign w_spec_val = w_zero ? (w_rem ? i_rs1 : '1)
                             : (w_rem ? '0 : i_rs1);

  assign w_cap = (r_state == S_BUSY) & i_div_ok & ~i_flush;

`ifdef DIV_RESULT_CACHE_EN
  logic            r_sgn;
  logic            r_c_vld, r_c_sgn;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_q, r_c_r;

  // Keyed on magnitudes: equal magnitudes give equal core outputs
  assign w_hit = r_c_vld & (r_c_sgn == w_sgn) &
                 (r_c_a == w_abs_a) & (r_c_b == w_abs_b);
  assign w_hit_val = fix(r_c_q, r_c_r, w_neg_a ^ w_neg_b,
                         w_neg_a, w_rem);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sgn   <= 1'b0;
      r_c_vld <= 1'b0;
      r_c_sgn <= 1'b0;
      r_c_a   <= '0;
      r_c_b   <= '0;
      r_c_q   <= '0;
      r_c_r   <= '0;
    end else begin
      if (w_acc & ~w_spec) r_sgn <= w_sgn;
      if (i_flush) begin
        r_c_vld <= 1'b0;
      end else if (w_cap) begin
        r_c_vld <= 1'b1;
        r_c_sgn <= r_sgn;
        r_c_a   <= r_a;
        r_c_b   <= r_b;
        r_c_q   <= i_div_res;
        r_c_r   <= i_div_rem;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_val = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) w_next = (w_spec | w_hit) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (i_flush)       w_next = S_IDLE;
        else if (i_div_ok) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (i_flush)       w_next = S_DRAIN;
        else if (i_div_ok) w_next = S_DONE;
      end
      S_DONE: begin
        if (i_flush | i_ready) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (i_div_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (r_state == S_IDLE);
    o_busy      = (r_state != S_IDLE);
    o_valid     = (r_state == S_DONE);
    o_div_start = (r_state == S_ISSUE);
    o_div_rs1   = r_a;
    o_div_rs2   = r_b;
    o_result    = r_result;
  end

  // Core operands only change on a normal accept, so they stay put through BUSY
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= 1'b0;
    end else begin
      if (w_acc) begin
        if (w_spec) begin
          r_result <= w_spec_val;
        end else if (w_hit) begin
          r_result <= w_hit_val;
        end else begin
          r_a     <= w_abs_a;
          r_b     <= w_abs_b;
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          r_rem   <= w_rem;
        end
      end
      if (w_cap) begin
        r_result <= fix(i_div_res, i_div_rem, r_neg_q, r_neg_r, r_rem);
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural 32-cycle core, vector table,
// hand-written flush/reset/stall sequences and randomized ops.
module tb_div_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready, o_valid, o_busy, o_div_start;
  logic [31:0] o_result, o_div_rs1, o_div_rs2;
  logic [31:0] c_res = '0;
  logic [31:0] c_rem = '0;
  logic        c_ok = 1'b1;
  int          c_cnt = 0;

  int total = 0;
  int bad = 0;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  div_ctrl #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(i_valid), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_ready(o_ready), .i_flush(i_flush),
    .o_valid(o_valid), .o_result(o_result),
    .i_ready(i_ready), .o_busy(o_busy),
    .o_div_start(o_div_start),
    .o_div_rs1(o_div_rs1), .o_div_rs2(o_div_rs2),
    .i_div_res(c_res), .i_div_rem(c_rem),
    .i_div_ok(c_ok)
  );

  always #5 i_clk = ~i_clk;

  // Divider core: takes 32 cycles, ok drops the cycle after a start
  always @(posedge i_clk) begin
    if (!i_rst) begin
      c_cnt <= 0;
      c_ok  <= 1'b1;
      c_res <= '0;
      c_rem <= '0;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) c_ok <= 1'b1;
    end else if (c_ok && o_div_start) begin
      c_cnt <= 32;
      c_ok  <= 1'b0;
      c_res <= (o_div_rs2 == 0) ? 32'hFFFF_FFFF : o_div_rs1 / o_div_rs2;
      c_rem <= (o_div_rs2 == 0) ? o_div_rs1 : o_div_rs1 % o_div_rs2;
    end
  end

  function automatic logic [31:0] ref_div(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 35;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) chk("send_timeout", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_flush = fl;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output int lat);
    send(op, a, b, 1'b0);
    lat = 0;
    res = 32'hDEAD_BEEF;
    while (lat < 300) begin
      @(negedge i_clk);
      lat++;
      if (o_valid) break;
    end
    if (!o_valid) begin
      chk("valid_timeout", 64'(o_valid), 64'd1);
      return;
    end
    res = o_result;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  initial begin : main
    logic [31:0] res, a, b, hold_exp;
    logic [1:0]  op;
    int          lat, n, sel;
    bit          seen;

    tbl[0]  = '{2'b01, 32'd100,        32'd7,        32'd14,         35};
    tbl[1]  = '{2'b11, 32'd100,        32'd7,        32'd2,          35};
    tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  35};
    tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  35};
    tbl[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         35};
    tbl[5]  = '{2'b00, 32'd5,          32'd0,        32'hFFFF_FFFF,  1};
    tbl[6]  = '{2'b10, 32'd5,          32'd0,        32'd5,          1};
    tbl[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[9]  = '{2'b01, 32'd5,          32'd0,        32'hFFFF_FFFF,  1};
    tbl[10] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 35};
    tbl[11] = '{2'b00, 32'h8000_0000,  32'd1,        32'h8000_0000,  35};
    tbl[12] = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2,         35};
    tbl[13] = '{2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE, 35};
    tbl[14] = '{2'b00, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 35};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ctl", {60'd0, o_ready, o_valid, o_busy, o_div_start},
        64'b1000);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_rs", {o_div_rs1, o_div_rs2}, 64'd0);
    i_rst = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      chk($sformatf("vec%0d_res", i), 64'(res), 64'(tbl[i].exp));
      if (tbl[i].lat == 1 || !CACHE)
        chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Stalled consumer: result must hold, no new request accepted
    send(2'b01, 32'd77, 32'd7, 1'b0);
    n = 0;
    while (!o_valid && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    hold_exp = 32'd11;
    repeat (10) begin
      @(negedge i_clk);
      chk("hold", {o_valid, o_ready, o_result}, {1'b1, 1'b0, hold_exp});
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;

    // Flush in BUSY: drain until the core finishes the abandoned op
    send(2'b01, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge i_clk);
    chk("busy_before_flush", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 200) begin
      @(negedge i_clk);
      n++;
      if (o_valid) seen = 1'b1;
      if (o_ready) break;
    end
    chk("drain_no_valid", 64'(seen), 64'd0);
    chk("drain_ready_at", 64'(n), 64'd25);
    do_op(2'b01, 32'd9, 32'd3, res, lat);
    chk("after_drain_res", 64'(res), 64'd3);
    chk("after_drain_lat", 64'(lat), 64'd35);

    // Flush on accept cycle drops the request
    send(2'b01, 32'd9, 32'd3, 1'b1);
    chk("flush_accept", {62'd0, o_ready, o_busy}, 64'b10);

    // Flush in ISSUE: core still starts, next op waits a full core pass
    send(2'b01, 32'd50, 32'd5, 1'b0);
    @(negedge i_clk);
    chk("issue_start", 64'(o_div_start), 64'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    do_op(2'b01, 32'd9, 32'd3, res, lat);
    chk("core_wait_res", 64'(res), 64'd3);
    chk("core_wait_lat", 64'(lat), 64'd66);

    // Reset mid-operation
    send(2'b01, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("midrst_ctl", {60'd0, o_ready, o_valid, o_busy, o_div_start},
        64'b1000);
    chk("midrst_rs", {o_div_rs1, o_div_rs2}, 64'd0);
    i_rst = 1'b1;
    do_op(2'b01, 32'd9, 32'd3, res, lat);
    chk("midrst_res", 64'(res), 64'd3);
    chk("midrst_lat", 64'(lat), 64'd35);

`ifdef DIV_RESULT_CACHE_EN
    do_op(2'b00, 32'd100, 32'd7, res, lat);
    chk("cache_fill_res", 64'(res), 64'd14);
    chk("cache_fill_lat", 64'(lat), 64'd35);
    do_op(2'b10, 32'd100, 32'd7, res, lat);
    chk("cache_hit_res", 64'(res), 64'd2);
    chk("cache_hit_lat", 64'(lat), 64'd1);
`endif

    for (int k = 0; k < 40; k++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = '0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        a = $urandom_range(0, 1000);
        b = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      do_op(op, a, b, res, lat);
      chk($sformatf("rnd%0d_res op=%0d a=%0h b=%0h", k, op, a, b),
          64'(res), 64'(ref_div(op, a, b)));
      if (ref_lat(op, a, b) == 1 || !CACHE)
        chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'(ref_lat(op, a, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
